// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master block-RAM arbiter.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 8;
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_e;

  // Read tag: {valid, master id}
  localparam int TAG_W   = 2;
  localparam int TAG_VLD = 1;
  localparam int TAG_ID  = 0;

  function automatic own_e own_of(input logic id);
    if (id) return OWN1;
    return OWN0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Per-master request/grant/read-return bundle shared by the arbiter and its masters.
interface ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arb_rdpipe.sv
// Two-stage read-tag delay line matching the RAM's address + data register latency.
module ram_arb_rdpipe
  import ram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             clr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic             id_o
);

  logic [TAG_W-1:0] tag_p1_q;
  logic [TAG_W-1:0] tag_p2_q;

  // p1: address registered toward RAM; p2: RAM data available
  always_ff @(posedge clk) begin
    if (clr_i) begin
      tag_p1_q <= '0;
      tag_p2_q <= '0;
    end else begin
      tag_p1_q <= tag_i;
      tag_p2_q <= tag_p1_q;
    end
  end

  assign vld_o = tag_p2_q[TAG_VLD];
  assign id_o  = tag_p2_q[TAG_ID];

endmodule

// File: rtl/ram_arbiter.sv
// Sticky-owner, burst-limited arbiter sharing one registered-read block RAM between two masters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  input  logic [DATA_W-1:0] dread,
  output logic [ADDR_W-1:0] c_raddr,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [DATA_W-1:0] dwrite,
  output logic              write_en
);

  localparam logic [RUN_W-1:0] BURST_C = RUN_W'(BURST);

  own_e              own_q, own_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              gnt0, gnt1, acc, sel;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [ADDR_W-1:0] c_raddr_q, c_waddr_q;
  logic [DATA_W-1:0] dwrite_q, rdata0_q, rdata1_q;
  logic              we_q;
  logic              vld_p2, id_p2, rv0, rv1;

  // Grant decision: depends only on req, own and run
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0.req && m1.req) begin
        case (own_q)
          OWN0:    if (run_q < BURST_C) gnt0 = 1'b1; else gnt1 = 1'b1;
          OWN1:    if (run_q < BURST_C) gnt1 = 1'b1; else gnt0 = 1'b1;
          default: gnt0 = 1'b1;
        endcase
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  assign acc     = gnt0 | gnt1;
  assign sel     = gnt1;
  assign a_we    = sel ? m1.we    : m0.we;
  assign a_addr  = sel ? m1.addr  : m0.addr;
  assign a_wdata = sel ? m1.wdata : m0.wdata;

  always_comb begin
    own_d = own_q;
    run_d = run_q;
    if (acc) begin
      if (own_q != own_of(sel)) begin
        own_d = own_of(sel);
        run_d = RUN_W'(1);
      end else if (run_q < BURST_C) begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q     <= IDLE;
      run_q     <= '0;
      we_q      <= 1'b0;
      c_raddr_q <= '0;
      c_waddr_q <= '0;
      dwrite_q  <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      own_q <= own_d;
      run_q <= run_d;
      we_q  <= acc & a_we;
      if (acc && a_we) begin
        c_waddr_q <= a_addr;
        dwrite_q  <= a_wdata;
      end
      if (acc && !a_we) c_raddr_q <= a_addr;
      if (rv0) rdata0_q <= dread;
      if (rv1) rdata1_q <= dread;
    end
  end

  ram_arb_rdpipe u_rdpipe (
    .clk   (clk),
    .clr_i (rst),
    .tag_i ({acc & ~a_we, sel}),
    .vld_o (vld_p2),
    .id_o  (id_p2)
  );

  // Returns and the write strobe are masked in the reset cycle so in-flight work is dropped
  assign rv0      = vld_p2 & ~id_p2 & ~rst;
  assign rv1      = vld_p2 &  id_p2 & ~rst;
  assign write_en = we_q & ~rst;

  assign c_raddr   = c_raddr_q;
  assign c_waddr   = c_waddr_q;
  assign dwrite    = dwrite_q;
  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? dread : rdata0_q;
  assign m1.rdata  = rv1 ? dread : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-master op queues drive requests, a monitor checks returns.
module tb_ram_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

  logic [DW-1:0] dread;
  logic [AW-1:0] c_raddr, c_waddr;
  logic [DW-1:0] dwrite;
  logic          write_en;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .dread    (dread),
    .c_raddr  (c_raddr),
    .c_waddr  (c_waddr),
    .dwrite   (dwrite),
    .write_en (write_en)
  );

  // Block RAM: one write port, registered read port
  logic [DW-1:0] ram    [0:511];
  logic [DW-1:0] shadow [0:511];
  always @(posedge clk) begin
    if (write_en) ram[c_waddr] <= dwrite;
    dread <= ram[c_raddr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
  } op_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] old;
  } exp_t;

  op_t  opq0[$], opq1[$];
  exp_t rq0[$], rq1[$], wq[$], aq[$];
  int   gnt_log[$];
  int   w0 = 0, w1 = 0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   own_m = -1, streak = 0;
  logic [DW-1:0] last0 = '0, last1 = '0;
  logic post_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbiter: sticky owner, at most BURST in a row while contested
  function automatic int model_grant(input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (own_m < 0) return 0;
    if (streak < BURST) return own_m;
    return 1 - own_m;
  endfunction

  task automatic push0(input logic we, input int addr, input int data, input int delay);
    if (opq0.size() == 0) w0 = delay;
    opq0.push_back('{we: we, addr: AW'(addr), wdata: DW'(data), delay: delay});
  endtask

  task automatic push1(input logic we, input int addr, input int data, input int delay);
    if (opq1.size() == 0) w1 = delay;
    opq1.push_back('{we: we, addr: AW'(addr), wdata: DW'(data), delay: delay});
  endtask

  task automatic accept(input int g, input op_t op);
    exp_t e;
    if (op.we) begin
      wq.push_back('{due: cyc + 1, addr: op.addr, data: op.wdata, old: shadow[op.addr]});
      shadow[op.addr] = op.wdata;
    end else begin
      aq.push_back('{due: cyc + 1, addr: op.addr, data: '0, old: '0});
      e = '{due: cyc + 2, addr: op.addr, data: shadow[op.addr], old: '0};
      if (g == 0) rq0.push_back(e);
      else        rq1.push_back(e);
    end
  endtask

  // One clock cycle: present requests, check grants at negedge, advance model
  task automatic tick();
    logic r0, r1;
    int   g;
    op_t  op;
    if (opq0.size() == 0) r0 = 1'b0;
    else if (w0 > 0) begin r0 = 1'b0; w0--; end
    else r0 = 1'b1;
    if (opq1.size() == 0) r1 = 1'b0;
    else if (w1 > 0) begin r1 = 1'b0; w1--; end
    else r1 = 1'b1;
    m0_bus.req   = r0;
    m0_bus.we    = r0 ? opq0[0].we    : 1'($urandom);
    m0_bus.addr  = r0 ? opq0[0].addr  : AW'($urandom);
    m0_bus.wdata = r0 ? opq0[0].wdata : DW'($urandom);
    m1_bus.req   = r1;
    m1_bus.we    = r1 ? opq1[0].we    : 1'($urandom);
    m1_bus.addr  = r1 ? opq1[0].addr  : AW'($urandom);
    m1_bus.wdata = r1 ? opq1[0].wdata : DW'($urandom);
    @(negedge clk);
    g = rst ? -1 : model_grant(r0, r1);
    chk("m0_gnt", 32'(m0_bus.gnt), 32'(g == 0));
    chk("m1_gnt", 32'(m1_bus.gnt), 32'(g == 1));
    if (rst) begin
      own_m  = -1;
      streak = 0;
    end else if (g >= 0) begin
      gnt_log.push_back(g);
      if (own_m != g) begin own_m = g; streak = 1; end
      else if (streak < BURST) streak++;
      if (g == 0) begin
        op = opq0.pop_front();
        if (opq0.size() > 0) w0 = opq0[0].delay;
      end else begin
        op = opq1.pop_front();
        if (opq1.size() > 0) w1 = opq1[0].delay;
      end
      accept(g, op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((opq0.size() + opq1.size()) > 0 && n < max) begin
      tick();
      n++;
    end
    chk("run_timeout", 32'(opq0.size() + opq1.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Monitor: RAM-side strobes and per-master returns
  always @(negedge clk) begin
    logic ew, e0, e1;
    if (rst) begin
      chk("m0_rvalid_rst", 32'(m0_bus.rvalid), 32'd0);
      chk("m1_rvalid_rst", 32'(m1_bus.rvalid), 32'd0);
      chk("write_en_rst",  32'(write_en),      32'd0);
      for (int i = wq.size() - 1; i >= 0; i--) shadow[wq[i].addr] = wq[i].old;
      wq.delete(); aq.delete(); rq0.delete(); rq1.delete();
      last0 = '0;
      last1 = '0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("c_raddr_rst", 32'(c_raddr), 32'd0);
        chk("c_waddr_rst", 32'(c_waddr), 32'd0);
        chk("dwrite_rst",  32'(dwrite),  32'd0);
        post_rst = 1'b0;
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        chk("c_raddr", 32'(c_raddr), 32'(aq[0].addr));
        void'(aq.pop_front());
      end
      ew = (wq.size() > 0) && (wq[0].due == cyc);
      chk("write_en", 32'(write_en), 32'(ew));
      if (ew) begin
        chk("c_waddr", 32'(c_waddr), 32'(wq[0].addr));
        chk("dwrite",  32'(dwrite),  32'(wq[0].data));
        void'(wq.pop_front());
      end
      e0 = (rq0.size() > 0) && (rq0[0].due == cyc);
      chk("m0_rvalid", 32'(m0_bus.rvalid), 32'(e0));
      if (e0) begin
        chk("m0_rdata", 32'(m0_bus.rdata), 32'(rq0[0].data));
        last0 = rq0[0].data;
        void'(rq0.pop_front());
      end else chk("m0_rdata_hold", 32'(m0_bus.rdata), 32'(last0));
      e1 = (rq1.size() > 0) && (rq1[0].due == cyc);
      chk("m1_rvalid", 32'(m1_bus.rvalid), 32'(e1));
      if (e1) begin
        chk("m1_rdata", 32'(m1_bus.rdata), 32'(rq1[0].data));
        last1 = rq1[0].data;
        void'(rq1.pop_front());
      end else chk("m1_rdata_hold", 32'(m1_bus.rdata), 32'(last1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]    = DW'(i * 37 + 11);
      shadow[i] = DW'(i * 37 + 11);
    end
    ram[5]    = 8'hA7;
    shadow[5] = 8'hA7;
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Single read of a preloaded location
    push0(1'b0, 'h005, 0, 0);
    run(20);
    repeat (4) tick();

    // Write from M1 followed immediately by a read of the same address from M0
    push1(1'b1, 'h1FF, 'h3C, 0);
    push0(1'b0, 'h1FF, 0, 1);
    run(20);
    repeat (4) tick();

    // Contested stream from IDLE: M0 x4, M1 x4, M0 x4
    do_reset(1);
    gnt_log.delete();
    for (int i = 0; i < 12; i++) begin
      push0(1'($urandom), $urandom_range(0, 511), $urandom, 0);
      push1(1'($urandom), $urandom_range(0, 511), $urandom, 0);
    end
    run(60);
    for (int i = 0; i < 12; i++) chk("burst_seq", 32'(gnt_log[i]), 32'((i / 4) % 2));
    repeat (4) tick();

    // Saturated run lets a late M1 request in at once; M0 then resumes
    gnt_log.delete();
    for (int i = 0; i < 9; i++) push0(1'b0, 'h040 + i, 0, 0);
    push1(1'b0, 'h050, 0, 6);
    run(40);
    chk("late_m1_gnt",  32'(gnt_log[6]), 32'd1);
    chk("m0_resume",    32'(gnt_log[7]), 32'd0);
    repeat (4) tick();

    // Reads interleaved between masters every cycle
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      push0(1'b0, 'h010 + 2 * i, 0, (i == 0) ? 0 : 1);
      push1(1'b0, 'h011 + 2 * i, 0, 1);
    end
    run(40);
    for (int i = 0; i < 8; i++) chk("interleave", 32'(gnt_log[i]), 32'(i % 2));
    repeat (4) tick();

    // Reset right after two reads and a write are accepted
    push0(1'b0, 'h020, 0, 0);
    push1(1'b0, 'h021, 0, 1);
    push0(1'b1, 'h022, 'h5A, 1);
    repeat (3) tick();
    push0(1'b0, 'h022, 0, 0);
    push1(1'b0, 'h021, 0, 0);
    gnt_log.delete();
    do_reset(1);
    run(20);
    chk("first_gnt_after_rst", 32'(gnt_log[0]), 32'd0);
    repeat (4) tick();

    // Random traffic with a reset while both masters are busy
    for (int i = 0; i < 200; i++) begin
      push0(1'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range('h010, 'h01F) : $urandom_range(0, 511),
            $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      push1(1'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range('h010, 'h01F) : $urandom_range(0, 511),
            $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    repeat (60) tick();
    do_reset(1);
    run(2000);
    repeat (4) tick();

    chk("pending_returns", 32'(rq0.size() + rq1.size() + wq.size() + aq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single 512x8 block RAM (one registered read port, one write port) between two masters: M0, the CPU, and M1, a serial loader/monitor that writes programs and dumps memory. It accepts at most one access per cycle and arbitrates with a sticky owner plus a burst limit. It drives the RAM address, data and write enable from registers, and returns read data to the master that issued the read with a fixed latency.

## Interface
- ADDR_W, 9, RAM address width
- DATA_W, 8, RAM data width
- BURST, 4, max consecutive grants to one master while the other is requesting (1..15)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  access address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  combinational accept strobe for the current cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse; rdata valid
- m0_rdata / m1_rdata  out  DATA_W  read data; holds its value between pulses
- dread  in  DATA_W  RAM read data
- c_raddr  out  ADDR_W  RAM read address (registered)
- c_waddr  out  ADDR_W  RAM write address (registered)
- dwrite  out  DATA_W  RAM write data (registered)
- write_en  out  1  RAM write enable (registered, one-cycle pulse)

## Operation
- Handshake:
  - A master raises req with we, addr and wdata stable.
  - The access is accepted in the cycle in which its gnt is high.
  - The master may drop req, or present the next access, in the following cycle.
  - gnt is never high without the matching req. At most one gnt is high per cycle.
- Arbiter state is `own`, one of IDLE, OWN0 or OWN1, plus a saturating run counter `run` (4 bits).
- Per-cycle grant decision:
  - Only one req high: grant that master.
  - Both high, own = IDLE: grant M0.
  - Both high, own = OWNx and run < BURST: grant x.
  - Both high, own = OWNx and run = BURST: grant the other master.
  - No req high: no grant. `own` and `run` hold their values.
- State update on a grant to master y:
  - If own != OWNy: own <= OWNy and run <= 1.
  - Otherwise: run <= min(run+1, BURST).
- IDLE is entered only by reset. It is never re-entered during operation.
- Accepted write: c_waddr <= addr, dwrite <= wdata, write_en <= 1 for exactly one cycle.
- Accepted read:
  - c_raddr <= addr.
  - A tag {valid, master id} enters a 2-stage pipeline.
  - When the tag exits the pipeline, rdata of the tagged master <= dread and its rvalid pulses.
  - c_raddr holds its value when no read is accepted.
- Back-to-back mixed traffic needs no forwarding. A write accepted in cycle N is committed at the end of N+1. A read accepted in N+1 or later samples the RAM at the end of N+2 or later, so it returns the new data.
- Reset values:
  - gnt 0, rvalid 0, write_en 0.
  - c_raddr 0, c_waddr 0, dwrite 0, rdata 0.
  - own IDLE, run 0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced for any read accepted before the reset. A write accepted in the cycle rst is high is dropped: write_en stays 0.
- The arbiter does not hold a master off while that master has reads in flight. A master may have up to 2 reads outstanding. Returns arrive in issue order.

## Timing
- Read latency: accepted in cycle N -> c_raddr valid in N+1 -> RAM registers the data at the end of N+1 -> rvalid and rdata valid in N+2.
- Write: accepted in N -> write_en high in N+1 -> RAM updated at the end of N+1.
- Throughput: one access per cycle sustained, in any mix of reads and writes and of masters.
- gnt depends combinationally on req, own and run only. There is no path from dread to gnt.

## Structure
- Shared package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Localparams for the `own` encoding: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Tag layout: bit 1 = valid, bit 0 = master id.
- One sub-module, ram_arb_rdpipe: a 2-stage tag shift register with synchronous clear. Its outputs are the tag-out valid and master id, which drive the rvalid and rdata steering.
- The grant logic, `own`/`run` update and RAM-side registers live in ram_arbiter.

## Test plan
- Reset, then M0 reads 0x005 with the RAM preloaded 0x005=0xA7 -> m0_gnt in cycle 0, c_raddr=0x005 in cycle 1, m0_rvalid with m0_rdata=0xA7 in cycle 2; m1_rvalid stays 0.
- M1 writes 0x1FF=0x3C, then M0 reads 0x1FF in the next cycle -> write_en high for one cycle with c_waddr=0x1FF, dwrite=0x3C; M0 receives 0x3C two cycles after its grant.
- Both masters hold req for 12 cycles with BURST=4 from reset -> grant sequence M0 x4, M1 x4, M0 x4; never two gnt in one cycle.
- M0 alone streams 6 reads, then M1 requests -> M1 granted in the very next cycle, because run is saturated at 4; M0 resumes after M1 drops req.
- Reads from M0 and M1 interleaved every cycle (addresses 0x010..0x017) -> each rvalid is routed to the issuing master, in order, 2 cycles after its grant.
- rst asserted one cycle after two reads and a write are accepted -> no rvalid follows, write_en stays 0 in the reset cycle, all outputs return to 0, and the first grant after reset follows the IDLE tie rule (M0).
